// File: rtl/stage_6combind.sv
// Clocked emulation of a six-stage two-phase bundled-data micropipeline.
// Each stage keeps a phase bit and a data word; tokens advance at most one stage per edge.
module stage_6combind #(
  parameter int STAGES = 6,
  parameter int WIDTH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  input  logic             ack_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             req_out,
  output logic             ack_out,
  output logic [WIDTH-1:0] data_out
);

  logic [STAGES-1:0]            r_q;
  logic [STAGES-1:0]            r_d;
  logic [STAGES-1:0][WIDTH-1:0] d_q;
  logic [STAGES-1:0][WIDTH-1:0] d_d;

  logic [STAGES-1:0]            req_up_s;
  logic [STAGES-1:0]            ack_dn_s;
  logic [STAGES-1:0][WIDTH-1:0] data_up_s;
  logic [STAGES-1:0]            fire_s;

  // Neighbour wiring: stage 0 faces the upstream port, the last stage faces ack_in.
  always_comb begin
    req_up_s  = {r_q[STAGES-2:0], req_in};
    ack_dn_s  = {ack_in, r_q[STAGES-1:1]};
    data_up_s = {d_q[STAGES-2:0], data_in};
  end

  // A stage fires when a new request phase arrives and its own token has been acknowledged.
  always_comb begin
    fire_s = '0;
    for (int k = 0; k < STAGES; k++) begin
      fire_s[k] = (req_up_s[k] != r_q[k]) && (r_q[k] == ack_dn_s[k]);
    end
  end

  // Next state: firing stages capture upstream phase and data, all others hold.
  always_comb begin
    r_d = r_q;
    d_d = d_q;
    for (int k = 0; k < STAGES; k++) begin
      if (fire_s[k]) begin
        r_d[k] = req_up_s[k];
        d_d[k] = data_up_s[k];
      end else begin
        r_d[k] = r_q[k];
        d_d[k] = d_q[k];
      end
    end
  end

  // Stage registers; reset wins over any firing and drops in-flight tokens.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
      d_q <= '0;
    end else begin
      r_q <= r_d;
      d_q <= d_d;
    end
  end

  assign ack_out  = r_q[0];
  assign req_out  = r_q[STAGES-1];
  assign data_out = d_q[STAGES-1];

endmodule

// File: tb/tb_stage_6combind.sv
// Self-checking bench for stage_6combind: directed latency/capacity/reset checks plus
// randomized producer/consumer traffic scored against an in-order token queue.
module tb_stage_6combind;

  localparam int WIDTH = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_in;
  logic             ack_in;
  logic [WIDTH-1:0] data_in;
  logic             req_out;
  logic             ack_out;
  logic [WIDTH-1:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [WIDTH-1:0] exp_q[$];
  int recv_cnt;
  int first_t;
  int last_t;

  int  acc_cnt = 0;
  int  con_cnt = 0;
  int  occ;
  int  max_occ = 0;
  logic pa = 1'b0;
  logic pi = 1'b0;

  stage_6combind #(.STAGES(6), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .ack_in   (ack_in),
    .data_in  (data_in),
    .req_out  (req_out),
    .ack_out  (ack_out),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tokens accepted upstream minus tokens consumed downstream may never exceed capacity.
  always @(negedge clk) begin
    if (!rst) begin
      acc_cnt = 0;
      con_cnt = 0;
    end else begin
      if (ack_out !== pa) acc_cnt = acc_cnt + 1;
      if (ack_in !== pi) con_cnt = con_cnt + 1;
      occ = acc_cnt - con_cnt;
      if (occ > max_occ) max_occ = occ;
    end
    pa = ack_out;
    pi = ack_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one token under the handshake contract and wait for its acknowledge.
  task automatic produce(input logic [WIDTH-1:0] v, input int idle);
    int t;
    repeat (idle) step();
    t = 0;
    while (req_in !== ack_out && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) chk("prod_ready_timeout", 32'd1, 32'd0);
    data_in = v;
    req_in  = ~req_in;
    exp_q.push_back(v);
    t = 0;
    do begin
      step();
      t++;
    end while (ack_out !== req_in && t < 100);
    if (t >= 100) chk("prod_ack_timeout", 32'd1, 32'd0);
  endtask

  // Wait for the next output token, score it, then acknowledge after dly cycles.
  task automatic consume(input int dly);
    int t;
    logic [WIDTH-1:0] e;
    t = 0;
    while (req_out === ack_in && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) begin
      chk("cons_timeout", 32'd1, 32'd0);
      return;
    end
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_token", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("order", 32'(data_out), 32'(e));
    end
    if (recv_cnt == 0) first_t = cyc;
    last_t = cyc;
    recv_cnt++;
    repeat (dly) step();
    ack_in = ~ack_in;
  endtask

  task automatic run_stream(input int n, input bit seq_data, input int pd, input int cd,
                            input bit chk_thru);
    recv_cnt = 0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          produce(seq_data ? WIDTH'(i + 1) : WIDTH'($urandom_range(0, 7)),
                  (pd > 0) ? int'($urandom_range(0, pd)) : 0);
        end
      end
      begin
        for (int j = 0; j < n; j++) begin
          consume((cd > 0) ? int'($urandom_range(0, cd)) : 0);
        end
      end
    join
    chk("stream_count", 32'(recv_cnt), 32'(n));
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    if (chk_thru) chk("thru_span", 32'(last_t - first_t), 32'(2 * (n - 1)));
    repeat (2) step();
  endtask

  // req_in has just toggled into an empty pipe: ack after 1 edge, req_out after 6.
  task automatic lat_check(input logic [WIDTH-1:0] v);
    logic p;
    logic np;
    p  = req_in;
    np = ~req_in;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 1) chk("lat_ack_out", 32'(ack_out), 32'(p));
      if (i < 6) chk("lat_req_early", 32'(req_out), 32'(np));
    end
    chk("lat_req_out", 32'(req_out), 32'(p));
    chk("lat_data_out", 32'(data_out), 32'(v));
  endtask

  initial begin
    int t;
    int acc0;
    int accepted;
    logic nreq;

    rst = 1'b0; req_in = 1'b1; ack_in = 1'b1; data_in = '0;
    step();
    step();
    chk("rst_req_out", 32'(req_out), 32'd0);
    chk("rst_ack_out", 32'(ack_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    req_in = 1'b0; ack_in = 1'b0;
    step();
    rst = 1'b1;
    step();

    // Single token traverses an empty pipe and stays put while unacknowledged.
    data_in = 3'd3;
    req_in  = 1'b1;
    lat_check(3'd3);
    repeat (3) step();
    chk("hold_req_out", 32'(req_out), 32'd1);
    chk("hold_data_out", 32'(data_out), 32'd3);
    ack_in = 1'b1;
    repeat (2) step();

    run_stream(6, 1'b1, 0, 0, 1'b0);
    run_stream(20, 1'b0, 0, 0, 1'b1);
    max_occ = 0;
    run_stream(40, 1'b0, 3, 4, 1'b0);
    chk("max_occ_within_6", 32'(max_occ <= 6), 32'd1);

    // Capacity: stalled downstream accepts exactly six tokens.
    max_occ  = 0;
    acc0     = acc_cnt;
    accepted = 0;
    for (int i = 1; i <= 7; i++) begin
      data_in = WIDTH'(i);
      req_in  = ~req_in;
      exp_q.push_back(WIDTH'(i));
      t = 0;
      do begin
        step();
        t++;
      end while (ack_out !== req_in && t < 15);
      if (ack_out === req_in) accepted++;
    end
    nreq = ~req_in;
    chk("cap_accepted", 32'(accepted), 32'd6);
    chk("cap_7th_blocked", 32'(ack_out), 32'(nreq));
    chk("cap_ack_toggles", 32'(acc_cnt - acc0), 32'd6);
    chk("cap_max_occ", 32'(max_occ), 32'd6);
    recv_cnt = 0;
    for (int i = 0; i < 7; i++) consume(0);
    repeat (2) step();
    chk("cap_7th_acked", 32'(ack_out), 32'(req_in));
    chk("cap_drained", 32'(exp_q.size()), 32'd0);
    chk("cap_recv", 32'(recv_cnt), 32'd7);

    // Reset with three tokens in flight, then a fresh token.
    for (int i = 0; i < 3; i++) begin
      data_in = WIDTH'(i + 2);
      req_in  = ~req_in;
      t = 0;
      do begin
        step();
        t++;
      end while (ack_out !== req_in && t < 15);
    end
    rst = 1'b0; req_in = 1'b0; ack_in = 1'b0; data_in = '0;
    step();
    chk("mid_rst_req_out", 32'(req_out), 32'd0);
    chk("mid_rst_ack_out", 32'(ack_out), 32'd0);
    chk("mid_rst_data_out", 32'(data_out), 32'd0);
    rst = 1'b1;
    exp_q.delete();
    data_in = 3'd5;
    req_in  = 1'b1;
    lat_check(3'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
